// File: rtl/weight_nibble_encoder_if.sv
// Handshake bundle between a weight producer and the nibble encoder.
// The slave modport is the encoder's view; the master modport is the producer/consumer side.
interface weight_nibble_encoder_if #(
    parameter int WIDTH             = 16,
    parameter int NUM_NIBBLES       = 4,
    parameter int LOG2_NIBBLE_WIDTH = 2
);
    logic                                      in_valid;
    logic [WIDTH-1:0]                          in_weight;
    logic                                      in_ready;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [3*NUM_NIBBLES-1:0]                  out_sel;
    logic [LOG2_NIBBLE_WIDTH*NUM_NIBBLES-1:0]  out_sl;
    logic [NUM_NIBBLES-1:0]                    out_zero;

    modport master (
        output in_valid, in_weight, out_ready,
        input  in_ready, out_valid, out_sel, out_sl, out_zero
    );

    modport slave (
        input  in_valid, in_weight, out_ready,
        output in_ready, out_valid, out_sel, out_sl, out_zero
    );
endinterface

// File: rtl/weight_nibble_encoder.sv
// Weight nibble encoder: splits a weight into nibbles and rewrites each nonzero nibble N as
// an odd alphabet A = 2*SEL+1 shifted left by SL = trailing-zero count, so N = A << SL.
// One nibble per cycle, LSB nibble first; the result is held until the consumer takes it.
module weight_nibble_encoder #(
    parameter int LOG2_WIDTH        = 4,
    parameter int WIDTH             = 2**LOG2_WIDTH,
    parameter int LOG2_NIBBLE_WIDTH = 2,
    parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
    parameter int NUM_NIBBLES       = WIDTH/NIBBLE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    weight_nibble_encoder_if.slave io_bus
);

    localparam int SEL_W = 3;
    localparam int SL_W  = LOG2_NIBBLE_WIDTH;
    // Counter must reach NUM_NIBBLES: one extra cycle drains the registered nibble.
    localparam int CNT_W = $clog2(NUM_NIBBLES + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEnc  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                          r_state;
    state_e                          w_state_next;
    logic [CNT_W-1:0]                r_cnt;
    logic [WIDTH-1:0]                r_weight;
    logic [NIBBLE_WIDTH-1:0]         r_nib;
    logic [SEL_W*NUM_NIBBLES-1:0]    r_sel;
    logic [SL_W*NUM_NIBBLES-1:0]     r_sl;
    logic [NUM_NIBBLES-1:0]          r_zero;

    logic                            w_in_ready;
    logic                            w_out_valid;
    logic                            w_capture;
    logic                            w_enc;
    logic [NIBBLE_WIDTH-1:0]         w_fetch_nib;
    logic [SEL_W-1:0]                w_sel;
    logic [SL_W-1:0]                 w_sl;
    logic                            w_zero;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_capture    = 1'b0;
        w_enc        = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_in_ready = !rst;
                if (io_bus.in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = StEnc;
                end
            end
            StEnc: begin
                w_enc = 1'b1;
                if (r_cnt == CNT_W'(NUM_NIBBLES)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Select nibble r_cnt of the stored weight; out-of-range counts read as zero.
    always_comb begin
        w_fetch_nib = '0;
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_fetch_nib = r_weight[NIBBLE_WIDTH*i +: NIBBLE_WIDTH];
            end
        end
    end

    // Decompose the registered nibble into alphabet index, shift and zero flag.
    always_comb begin
        w_sel  = '0;
        w_sl   = '0;
        w_zero = 1'b0;
        if (r_nib == '0) begin
            w_zero = 1'b1;
        end else if (r_nib[0]) begin
            w_sel = r_nib[3:1];
        end else if (r_nib[1]) begin
            w_sl  = SL_W'(1);
            w_sel = {1'b0, r_nib[3:2]};
        end else if (r_nib[2]) begin
            w_sl  = SL_W'(2);
            w_sel = {2'b00, r_nib[3]};
        end else begin
            w_sl  = SL_W'(3);
        end
    end

    // Datapath: capture the weight, fetch nibble k, and write field k-1 from the previous fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_weight <= '0;
            r_nib    <= '0;
            r_sel    <= '0;
            r_sl     <= '0;
            r_zero   <= '1;
        end else if (w_capture) begin
            r_weight <= io_bus.in_weight;
            r_cnt    <= '0;
        end else if (w_enc) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_nib <= w_fetch_nib;
            for (int i = 0; i < NUM_NIBBLES; i++) begin
                if (r_cnt == CNT_W'(i + 1)) begin
                    r_sel[SEL_W*i +: SEL_W] <= w_sel;
                    r_sl[SL_W*i +: SL_W]    <= w_sl;
                    r_zero[i]               <= w_zero;
                end
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.out_sel   = r_sel;
    assign io_bus.out_sl    = r_sl;
    assign io_bus.out_zero  = r_zero;

endmodule
